// File: rtl/rv32i_exec_mem_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_params (package)
// Purpose  : Shared widths, opcodes and control encodings for the RV32I
//            execute/memory slice, plus the func3/func7 -> ALU op helper.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_params;

  localparam int DATA_WIDTH = 32;
  localparam int MEM_DEPTH  = 256;
  localparam int MEM_AW     = 8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Map func3 and func7[5] onto an ALU op; SUB only exists for register ops,
  // while SRA is selected by func7[5] for both register and immediate shifts.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7b5,
                                            input logic       is_rtype);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_exec_mem_core_alu.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_alu_unit
// Purpose  : Combinational RV32I ALU (modulo-2^32 arithmetic, 5-bit shifts).
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_alu_unit
  import rv32i_params::*;
(
  input  logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  logic [4:0] w_shamt;
  assign w_shamt = b[4:0];

  // Select the operation result; undefined control codes produce zero.
  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << w_shamt;
      ALU_SRL:  result = a >> w_shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> w_shamt);
      ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/rv32i_exec_mem_core.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_exec_mem_core
// Purpose  : RV32I main decoder, ALU and 256x32 data memory with a preload
//            port (active until init_done) and a combinational debug read.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_exec_mem_core
  import rv32i_params::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [DATA_WIDTH-1:0] sign_ext,
  output logic                  branch,
  output logic [2:0]            imm_src,
  output logic                  mem_read,
  output logic                  mem_2_reg,
  output logic [3:0]            alu_ctrl,
  output logic                  mem_write,
  output logic                  alu_src,
  output logic                  reg_write,
  output logic [1:0]            wrt_back_src,
  output logic [DATA_WIDTH-1:0] alu_results,
  output logic                  alu_zero,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  init_done,
  input  logic [9:0]            ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_dat,
  input  logic                  ld_enb,
  input  logic [9:0]            debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data
);

  logic                  w_mem_read;
  logic                  w_mem_write;
  logic                  w_reg_write;
  logic                  w_branch;
  logic [DATA_WIDTH-1:0] w_alu_b;
  logic                  w_wr_en;
  logic [MEM_AW-1:0]     w_wr_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic                  w_unused_bits;

  // Main decoder: every control starts at 0 so unknown opcodes stay inert.
  always_comb begin
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    imm_src      = IMM_I;
    mem_2_reg    = 1'b0;
    alu_ctrl     = ALU_ADD;
    alu_src      = 1'b0;
    wrt_back_src = WB_MEM;
    case (opcode)
      OP_R: begin
        w_reg_write  = 1'b1;
        wrt_back_src = WB_ALU;
        alu_ctrl     = alu_decode(func3, func7[5], 1'b1);
      end
      OP_I_ALU: begin
        w_reg_write  = 1'b1;
        alu_src      = 1'b1;
        wrt_back_src = WB_ALU;
        alu_ctrl     = alu_decode(func3, func7[5], 1'b0);
      end
      OP_LOAD: begin
        w_mem_read  = 1'b1;
        mem_2_reg   = 1'b1;
        w_reg_write = 1'b1;
        alu_src     = 1'b1;
      end
      OP_STORE: begin
        w_mem_write = 1'b1;
        alu_src     = 1'b1;
        imm_src     = IMM_S;
      end
      OP_BRANCH: begin
        imm_src  = IMM_B;
        alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        w_reg_write  = 1'b1;
        imm_src      = IMM_J;
        wrt_back_src = WB_PC4;
      end
      default: ;
    endcase
  end

  // Branch resolution is kept apart from the decoder so the ALU zero flag
  // feeds forward only, with no loop back through alu_ctrl.
  always_comb begin
    w_branch = 1'b0;
    if (opcode == OP_BRANCH) begin
      if (func3 == 3'b000)      w_branch = alu_zero;
      else if (func3 == 3'b001) w_branch = ~alu_zero;
    end else if (opcode == OP_JAL) begin
      w_branch = 1'b1;
    end
  end

  // Side-effecting controls are held off while reset is asserted.
  assign branch    = rst & w_branch;
  assign mem_read  = rst & w_mem_read;
  assign mem_write = rst & w_mem_write;
  assign reg_write = rst & w_reg_write;

  assign w_alu_b = alu_src ? sign_ext : src2;

  rv32i_alu_unit u_alu (
    .alu_ctrl (alu_ctrl),
    .a        (src1),
    .b        (w_alu_b),
    .result   (alu_results),
    .zero     (alu_zero)
  );

  // Preload port owns the memory until init_done; afterwards the store path.
  assign w_wr_en   = init_done ? mem_write          : ld_enb;
  assign w_wr_idx  = init_done ? alu_results[9:2]   : ld_addr[9:2];
  assign w_wr_data = init_done ? src2               : ld_dat;

  // Word memory: asynchronous clear drops any write pending at reset entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  assign mem_rdata  = mem_read ? r_mem[alu_results[9:2]] : '0;
  assign debug_data = r_mem[debug_addr[9:2]];

  assign w_unused_bits = ^{func7[6], func7[4:0], alu_results[31:10],
                           alu_results[1:0], ld_addr[1:0], debug_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_rv32i_exec_mem_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_exec_mem_core
// Purpose  : Scoreboard bench for the RV32I execute/memory slice.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_exec_mem_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic [31:0] src1 = '0, src2 = '0, sign_ext = '0;
  logic        branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, alu_zero;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wrt_back_src;
  logic [31:0] alu_results, mem_rdata, debug_data;
  logic        init_done = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_dat = '0;
  logic        ld_enb = 1'b0;
  logic [9:0]  debug_addr = '0;

  localparam int S_ALU = 0, S_ZERO = 1, S_RDATA = 2, S_DEBUG = 3, S_BRANCH = 4,
                 S_REGW = 5, S_WBS = 6, S_IMM = 7, S_MEMW = 8, S_MEMR = 9,
                 S_M2R = 10, S_CTRL = 11, S_ASRC = 12, S_ALLCTL = 13;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  rv32i_exec_mem_core dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .src1(src1), .src2(src2), .sign_ext(sign_ext),
    .branch(branch), .imm_src(imm_src), .mem_read(mem_read),
    .mem_2_reg(mem_2_reg), .alu_ctrl(alu_ctrl), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .wrt_back_src(wrt_back_src),
    .alu_results(alu_results), .alu_zero(alu_zero), .mem_rdata(mem_rdata),
    .init_done(init_done), .ld_addr(ld_addr), .ld_dat(ld_dat), .ld_enb(ld_enb),
    .debug_addr(debug_addr), .debug_data(debug_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_ALU:    return alu_results;
      S_ZERO:   return {31'b0, alu_zero};
      S_RDATA:  return mem_rdata;
      S_DEBUG:  return debug_data;
      S_BRANCH: return {31'b0, branch};
      S_REGW:   return {31'b0, reg_write};
      S_WBS:    return {30'b0, wrt_back_src};
      S_IMM:    return {29'b0, imm_src};
      S_MEMW:   return {31'b0, mem_write};
      S_MEMR:   return {31'b0, mem_read};
      S_M2R:    return {31'b0, mem_2_reg};
      S_CTRL:   return {28'b0, alu_ctrl};
      S_ASRC:   return {31'b0, alu_src};
      default:  return {15'b0, branch, imm_src, mem_read, mem_2_reg, alu_ctrl,
                        mem_write, alu_src, reg_write, wrt_back_src};
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sbq.push_back(e);
  endtask

  // Settle combinational paths, then compare every queued expectation.
  task automatic drain();
    exp_t e;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    opcode = op; func3 = f3; func7 = f7; src1 = a; src2 = b; sign_ext = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] addr, input logic [31:0] dat);
    ld_addr = addr; ld_dat = dat; ld_enb = 1'b1;
    tick();
    ld_enb = 1'b0;
  endtask

  initial begin
    // Reset state: load opcode held during reset must not assert controls.
    drive(7'b0000011, 3'b010, 7'h00, 32'h0, 32'h0, 32'h4);
    push("rst_memr", S_MEMR, 0);
    push("rst_regw", S_REGW, 0);
    push("rst_debug", S_DEBUG, 0);
    drain();

    tick();
    rst = 1'b1;
    drive(7'b1111111, 3'b0, 7'h0, 32'h0, 32'h0, 32'h0);
    tick();
    preload(10'h000, 32'h3);
    preload(10'h004, 32'h2);
    init_done = 1'b1;

    // R-type SUB
    drive(7'b0110011, 3'b000, 7'b0100000, 32'h1, 32'h2, 32'h0);
    push("sub_alu", S_ALU, 32'hFFFFFFFF);
    push("sub_zero", S_ZERO, 0);
    push("sub_regw", S_REGW, 1);
    push("sub_wbs", S_WBS, 2'b01);
    push("sub_ctrl", S_CTRL, 4'b0001);
    drain();

    // LW from preloaded word 1
    drive(7'b0000011, 3'b010, 7'h0, 32'h0, 32'h0, 32'h4);
    push("lw_rdata", S_RDATA, 32'h2);
    push("lw_wbs", S_WBS, 2'b00);
    push("lw_m2r", S_M2R, 1);
    push("lw_asrc", S_ASRC, 1);
    drain();

    // SW 0xC, then verify via debug port after the edge
    drive(7'b0100011, 3'b010, 7'h0, 32'h0, 32'hFFFFFFFF, 32'hC);
    debug_addr = 10'h00C;
    push("sw_memw", S_MEMW, 1);
    push("sw_imm", S_IMM, 3'b001);
    push("sw_rdata0", S_RDATA, 0);
    push("sw_regw", S_REGW, 0);
    push("sw_dbg_pre", S_DEBUG, 0);
    drain();
    tick();
    push("sw_dbg_post", S_DEBUG, 32'hFFFFFFFF);
    drain();

    // Store to word 0: old data visible before the edge, new after
    drive(7'b0100011, 3'b010, 7'h0, 32'h0, 32'h12345678, 32'h0);
    debug_addr = 10'h000;
    push("rdw_old", S_DEBUG, 32'h3);
    drain();
    tick();
    push("rdw_new", S_DEBUG, 32'h12345678);
    drain();

    // Address above bit 9 wraps: 0x40C lands on word 3
    drive(7'b0100011, 3'b010, 7'h0, 32'h400, 32'hCAFEF00D, 32'hC);
    debug_addr = 10'h00E;
    tick();
    push("wrap_dbg", S_DEBUG, 32'hCAFEF00D);
    drain();

    // Branches and JAL
    drive(7'b1100011, 3'b000, 7'h0, 32'h5, 32'h5, 32'h0);
    push("beq_br", S_BRANCH, 1);
    push("beq_zero", S_ZERO, 1);
    push("beq_imm", S_IMM, 3'b010);
    drain();
    drive(7'b1100011, 3'b001, 7'h0, 32'h5, 32'h5, 32'h0);
    push("bne_br", S_BRANCH, 0);
    drain();
    drive(7'b1100011, 3'b001, 7'h0, 32'h5, 32'h6, 32'h0);
    push("bne_taken", S_BRANCH, 1);
    drain();
    drive(7'b1101111, 3'b000, 7'h0, 32'h0, 32'h0, 32'h0);
    push("jal_br", S_BRANCH, 1);
    push("jal_imm", S_IMM, 3'b100);
    push("jal_wbs", S_WBS, 2'b10);
    push("jal_regw", S_REGW, 1);
    drain();

    // Shifts and comparisons
    drive(7'b0010011, 3'b101, 7'b0100000, 32'h80000000, 32'h0, 32'h4);
    push("srai", S_ALU, 32'hF8000000);
    drain();
    drive(7'b0010011, 3'b101, 7'b0000000, 32'h80000000, 32'h0, 32'h4);
    push("srli", S_ALU, 32'h08000000);
    drain();
    drive(7'b0010011, 3'b000, 7'b0100000, 32'h10, 32'h0, 32'h3);
    push("addi_f7", S_ALU, 32'h13);
    drain();
    drive(7'b0110011, 3'b011, 7'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
    push("sltu", S_ALU, 0);
    drain();
    drive(7'b0110011, 3'b010, 7'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
    push("slt", S_ALU, 1);
    drain();
    drive(7'b0110011, 3'b001, 7'h0, 32'h1, 32'h25, 32'h0);
    push("sll_mod32", S_ALU, 32'h20);
    drain();

    // Unknown opcode: all controls low
    drive(7'b1111111, 3'b000, 7'h0, 32'h5, 32'h5, 32'h0);
    push("unk_ctl", S_ALLCTL, 0);
    drain();

    // Reset asserted during a store: no write, memory cleared
    drive(7'b0100011, 3'b010, 7'h0, 32'h0, 32'hAAAA5555, 32'h10);
    debug_addr = 10'h010;
    push("rsw_memw_pre", S_MEMW, 1);
    drain();
    rst = 1'b0;
    push("rsw_memw", S_MEMW, 0);
    drain();
    tick();
    push("rsw_word", S_DEBUG, 0);
    drain();
    debug_addr = 10'h00C;
    push("rsw_clr_c", S_DEBUG, 0);
    drain();
    debug_addr = 10'h000;
    push("rsw_clr_0", S_DEBUG, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
